toggle_arbiter: RTL and testbench

TOGGLE_ARBITER -- requirements
Module: toggle_arbiter

---
 rtl/toggle_arbiter.sv | 136 +++++++++++++
 tb/tb_toggle_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_arbiter.sv
// Toggle arbiter: captures rising edges on req_in as pending flags, grants
// one requester at a time in rotating order, flips that requester's toggle
// bit, then enforces GAP idle cycles before the next grant.
module toggle_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned GAP = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    input  logic         hold,
    output logic [N-1:0] tog_out,
    output logic [N-1:0] grant,
    output logic [N-1:0] pend,
    output logic         busy,
    output logic         overrun
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StSpace} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   prev_q;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   tog_q, tog_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           ovr_q, ovr_d;
    logic [PW-1:0]  ptr_q, ptr_d;

    logic [N-1:0]   edge_det;
    logic [N-1:0]   clr;
    logic [PW-1:0]  win_idx;
    logic           win_found;
    logic           start;

    // State register: every flop, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            tog_q   <= '0;
            grant_q <= '0;
            ovr_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= req_in;
            pend_q  <= pend_d;
            tog_q   <= tog_d;
            grant_q <= grant_d;
            ovr_q   <= ovr_d;
            ptr_q   <= ptr_d;
        end
    end

    // Winner: first pending bit at or above ptr, wrapping from N-1 to 0.
    always_comb begin
        logic [PW:0] sum;
        sum       = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            if (!win_found && pend_q[sum[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[PW-1:0];
            end
        end
    end

    // Next-state logic for the FSM and gap counter; hold only matters in idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (GAP > 0) begin
                    state_d = StSpace;
                    cnt_d   = 4'(GAP - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            StSpace: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath: edge capture, grant issue, toggle, pointer advance, overrun.
    always_comb begin
        start    = (state_q == StIdle) && !hold && (pend_q != '0) && win_found;
        edge_det = req_in & ~prev_q;
        clr      = start ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
        // A new edge in the same cycle as the clear re-arms the flag.
        pend_d   = (pend_q & ~clr) | edge_det;
        ovr_d    = ovr_q | (|(edge_det & pend_q & ~clr));
        tog_d    = tog_q ^ clr;
        grant_d  = clr;
        ptr_d    = ptr_q;
        if (start) begin
            ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        tog_out = tog_q;
        grant   = grant_q;
        pend    = pend_q;
        overrun = ovr_q;
        busy    = (state_q != StIdle);
    end

endmodule

// File: tb/tb_toggle_arbiter.sv
// Directed bench for toggle_arbiter: a GAP=2 instance plus a GAP=0 instance.
module tb_toggle_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic       hold;
    logic [3:0] tog_out, grant, pend;
    logic       busy, overrun;

    logic [3:0] req0;
    logic       hold0;
    logic [3:0] tog0, grant0, pend0;
    logic       busy0, overrun0;

    int checks;
    int failures;

    toggle_arbiter #(.N(4), .GAP(2)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req_in),
        .hold    (hold),
        .tog_out (tog_out),
        .grant   (grant),
        .pend    (pend),
        .busy    (busy),
        .overrun (overrun)
    );

    toggle_arbiter #(.N(4), .GAP(0)) u_gap0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req0),
        .hold    (hold0),
        .tog_out (tog0),
        .grant   (grant0),
        .pend    (pend0),
        .busy    (busy0),
        .overrun (overrun0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_in = '0;
        hold   = 1'b0;
        req0   = '0;
        hold0  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        req_in = 4'b1111;
        hold   = 1'b0;
        tick();
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tog_out, grant, pend, busy, overrun} !== 14'd0) begin
            failures++;
            $display("FAIL reset_async outs=%b expected 0", {tog_out, grant, pend, busy, overrun});
        end
        req_in = '0;
        tick();
        tick();
        checks++;
        if ({tog_out, grant, pend, busy, overrun} !== 14'd0) begin
            failures++;
            $display("FAIL reset_held outs=%b expected 0", {tog_out, grant, pend, busy, overrun});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_pulse();
        int busy_cnt;
        do_reset();
        req_in = 4'b0100;
        tick();
        checks++;
        if (pend !== 4'b0100 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL pulse_pend pend=%b grant=%b expected 0100/0000", pend, grant);
        end
        req_in = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0100 || tog_out !== 4'b0100 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL pulse_grant grant=%b tog=%b pend=%b expected 0100/0100/0000",
                     grant, tog_out, pend);
        end
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_cnt++;
            tick();
        end
        checks++;
        if (busy_cnt != 3) begin
            failures++;
            $display("FAIL pulse_busy cycles=%0d expected 3", busy_cnt);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [3];
        logic [3:0] exp_t [3];
        int stray;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
        exp_t[0] = 4'b0001; exp_t[1] = 4'b0011; exp_t[2] = 4'b1011;
        do_reset();
        req_in = 4'b1011;
        tick();
        checks++;
        if (pend !== 4'b1011) begin
            failures++;
            $display("FAIL rot_pend pend=%b expected 1011", pend);
        end
        stray = 0;
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (grant !== exp_g[g] || tog_out !== exp_t[g]) begin
                failures++;
                $display("FAIL rot_grant%0d grant=%b tog=%b expected %b/%b",
                         g, grant, tog_out, exp_g[g], exp_t[g]);
            end
            if (g < 2) begin
                for (int j = 0; j < 3; j++) begin
                    tick();
                    if (grant !== 4'b0000) stray++;
                end
            end
        end
        checks++;
        if (stray != 0 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL rot_gaps stray=%0d pend=%b expected 0/0000", stray, pend);
        end
        // Pointer should be back at 0: bits 3 and 0 together must pick bit 0.
        req_in = 4'b0000;
        tick();
        req_in = 4'b1001;
        tick();
        tick();
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL rot_ptr_wrap grant=%b expected 0001", grant);
        end
    endtask

    task automatic test_overrun();
        int extra;
        do_reset();
        hold   = 1'b1;
        req_in = 4'b0010;
        tick();
        req_in = 4'b0000;
        tick();
        checks++;
        if (overrun !== 1'b0 || pend !== 4'b0010) begin
            failures++;
            $display("FAIL ovr_first ovr=%b pend=%b expected 0/0010", overrun, pend);
        end
        req_in = 4'b0010;
        tick();
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_set ovr=%b expected 1", overrun);
        end
        req_in = 4'b0000;
        hold   = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0010 || tog_out !== 4'b0010 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL ovr_grant grant=%b tog=%b pend=%b expected 0010/0010/0000",
                     grant, tog_out, pend);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (grant !== 4'b0000) extra++;
        end
        checks++;
        if (extra != 0 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_single extra=%0d ovr=%b expected 0/1", extra, overrun);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        hold   = 1'b1;
        req_in = 4'b0010;
        tick();
        req_in = 4'b0000;
        tick();
        hold   = 1'b0;
        req_in = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010 || pend !== 4'b0010 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL setwin_grant grant=%b pend=%b ovr=%b expected 0010/0010/0",
                     grant, pend, overrun);
        end
        req_in = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (grant !== 4'b0010 || tog_out !== 4'b0000) begin
            failures++;
            $display("FAIL setwin_regrant grant=%b tog=%b expected 0010/0000", grant, tog_out);
        end
    endtask

    task automatic test_hold();
        int leak;
        do_reset();
        hold   = 1'b1;
        req_in = 4'b0001;
        tick();
        req_in = 4'b0000;
        leak   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant !== 4'b0000 || busy !== 1'b0 || pend !== 4'b0001) leak++;
        end
        checks++;
        if (leak != 0) begin
            failures++;
            $display("FAIL hold_block bad_cycles=%0d expected 0", leak);
        end
        hold = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL hold_release grant=%b expected 0001", grant);
        end
    endtask

    task automatic test_reset_mid_space();
        do_reset();
        req_in = 4'b0001;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || grant !== 4'b0000 || tog_out !== 4'b0001) begin
            failures++;
            $display("FAIL space_state busy=%b grant=%b tog=%b expected 1/0000/0001",
                     busy, grant, tog_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tog_out, grant, pend, busy, overrun} !== 14'd0) begin
            failures++;
            $display("FAIL space_abort outs=%b expected 0", {tog_out, grant, pend, busy, overrun});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (pend !== 4'b0001 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL release_pend pend=%b grant=%b expected 0001/0000", pend, grant);
        end
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL release_grant grant=%b expected 0001", grant);
        end
        req_in = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        do_reset();
        req0 = 4'b1111;
        tick();
        checks++;
        if (pend0 !== 4'b1111) begin
            failures++;
            $display("FAIL gap0_pend pend=%b expected 1111", pend0);
        end
        for (int g = 0; g < 4; g++) begin
            exp = 4'b0001 << g;
            tick();
            checks++;
            if (grant0 !== exp) begin
                failures++;
                $display("FAIL gap0_grant%0d grant=%b expected %b", g, grant0, exp);
            end
            tick();
            checks++;
            if (grant0 !== 4'b0000) begin
                failures++;
                $display("FAIL gap0_idle%0d grant=%b expected 0000", g, grant0);
            end
        end
        checks++;
        if (tog0 !== 4'b1111 || pend0 !== 4'b0000 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL gap0_final tog=%b pend=%b busy=%b expected 1111/0000/0",
                     tog0, pend0, busy0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req_in   = '0;
        hold     = 1'b0;
        req0     = '0;
        hold0    = 1'b0;
        test_reset();
        test_single_pulse();
        test_rotation();
        test_overrun();
        test_set_wins();
        test_hold();
        test_reset_mid_space();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
